// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority encoder / round-robin arbiter.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 for index widths; returns at least 1 for v >= 2.
  function automatic int clog2(input int unsigned v);
    int r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational descending modular search: scans req from start downward,
// wrapping from 0 to N-1, and reports the first set index.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned pos;

  // First set bit in the order start, start-1, ..., 0, N-1, ..., start+1.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(start) + 32'(N) - k) % 32'(N);
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = W'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-input priority encoder with registered output, valid/ready handshake and
// selectable fixed-priority (highest index wins) or round-robin arbitration.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_grant
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state;
  logic [W-1:0] last_idx;
  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         load;

  assign load = (state == IDLE) || out_ready;

  // A load in HOLD always coincides with a transfer, so the search must use
  // the index being handed over now rather than the not-yet-updated last_idx.
  always_comb begin
    ptr = (state == HOLD) ? out_idx : last_idx;
    if (mode == MODE_RR && ptr != '0) start = ptr - W'(1);
    else                              start = W'(N - 1);
  end

  prio_pick #(.N(N)) u_pick (
    .req   (req),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Handshake FSM, output registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_grant <= '0;
      last_idx  <= '0;
    end else begin
      if (state == HOLD && out_ready) last_idx <= out_idx;
      if (load) begin
        if (pick_any) begin
          out_idx   <= pick_idx;
          out_grant <= N'(1) << pick_idx;
          out_valid <= 1'b1;
          state     <= HOLD;
        end else begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr: N=8 and N=5 instances, expected
// grant indices queued as stimulus is driven and popped as results transfer.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] req8 = '0;
  logic       mode8 = 1'b0;
  logic       rdy8 = 1'b0;
  logic       v8;
  logic [2:0] idx8;
  logic [7:0] g8;

  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0;
  logic       rdy5 = 1'b0;
  logic       v5;
  logic [2:0] idx5;
  logic [4:0] g5;

  int unsigned exp_q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req8),
    .mode      (mode8),
    .out_ready (rdy8),
    .out_valid (v8),
    .out_idx   (idx8),
    .out_grant (g8)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req5),
    .mode      (mode5),
    .out_ready (rdy5),
    .out_valid (v5),
    .out_idx   (idx5),
    .out_grant (g5)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req8 = '0; mode8 = 1'b0; rdy8 = 1'b0;
    req5 = '0; mode5 = 1'b0; rdy5 = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int unsigned e;
    logic [7:0] eg;
    do_reset();
    tests++;
    if (v8 !== 1'b0 || idx8 !== 3'd0 || g8 !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: valid=%b idx=%0d grant=%h required 0/0/00", v8, idx8, g8);
    end
    mode8 = 1'b0; req8 = 8'hFF; rdy8 = 1'b0;
    step();
    tests++;
    if (v8 !== 1'b1 || idx8 !== 3'd7) begin
      fails++;
      $display("FAIL reset_pre_hold: valid=%b idx=%0d required 1/7", v8, idx8);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (v8 !== 1'b0 || idx8 !== 3'd0 || g8 !== 8'h00) begin
      fails++;
      $display("FAIL reset_async: valid=%b idx=%0d grant=%h required 0/0/00", v8, idx8, g8);
    end
    @(negedge clk);
    rst_n = 1'b1; mode8 = 1'b1; req8 = 8'hFF; rdy8 = 1'b1;
    exp_q.push_back(7);
    step();
    e = exp_q.pop_front();
    eg = 8'(1) << e;
    tests++;
    if (v8 !== 1'b1 || idx8 !== 3'(e) || g8 !== eg) begin
      fails++;
      $display("FAIL reset_first_rr: valid=%b idx=%0d grant=%h required 1/%0d/%h", v8, idx8, g8, e, eg);
    end
  endtask

  task automatic test_fixed();
    int unsigned e;
    logic [7:0] eg;
    do_reset();
    mode8 = 1'b0; req8 = 8'h28; rdy8 = 1'b1;
    exp_q.push_back(5);
    step();
    e = exp_q.pop_front();
    eg = 8'(1) << e;
    tests++;
    if (v8 !== 1'b1 || idx8 !== 3'(e) || g8 !== eg) begin
      fails++;
      $display("FAIL fixed_28: valid=%b idx=%0d grant=%h required 1/%0d/%h", v8, idx8, g8, e, eg);
    end
    req8 = 8'h00;
    step();
    tests++;
    if (v8 !== 1'b0) begin
      fails++;
      $display("FAIL fixed_empty: valid=%b required 0", v8);
    end
  endtask

  task automatic test_backpressure();
    int unsigned e;
    logic [7:0] eg;
    mode8 = 1'b0; req8 = 8'h28; rdy8 = 1'b1;
    step();
    rdy8 = 1'b0; req8 = 8'h80;
    for (int unsigned c = 0; c < 4; c++) begin
      mode8 = ~mode8;
      step();
      tests++;
      if (v8 !== 1'b1 || idx8 !== 3'd5 || g8 !== 8'h20) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%b idx=%0d grant=%h required 1/5/20", c, v8, idx8, g8);
      end
    end
    rdy8 = 1'b1; mode8 = 1'b0;
    exp_q.push_back(7);
    step();
    e = exp_q.pop_front();
    eg = 8'(1) << e;
    tests++;
    if (v8 !== 1'b1 || idx8 !== 3'(e) || g8 !== eg) begin
      fails++;
      $display("FAIL stall_release: valid=%b idx=%0d grant=%h required 1/%0d/%h", v8, idx8, g8, e, eg);
    end
  endtask

  task automatic test_round_robin();
    int unsigned e;
    logic [7:0] eg;
    do_reset();
    mode8 = 1'b1; req8 = 8'hFF; rdy8 = 1'b1;
    for (int unsigned k = 0; k < 8; k++) exp_q.push_back(7 - k);
    exp_q.push_back(7);
    for (int unsigned c = 0; c < 9; c++) begin
      step();
      e = exp_q.pop_front();
      eg = 8'(1) << e;
      tests++;
      if (v8 !== 1'b1 || idx8 !== 3'(e) || g8 !== eg) begin
        fails++;
        $display("FAIL rr_seq[%0d]: valid=%b idx=%0d grant=%h required 1/%0d/%h", c, v8, idx8, g8, e, eg);
      end
    end
  endtask

  task automatic test_n5();
    int unsigned e;
    logic [4:0] eg;
    do_reset();
    mode5 = 1'b1; req5 = 5'b10001; rdy5 = 1'b1;
    exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(0);
    for (int unsigned c = 0; c < 7; c++) begin
      if (c == 4) begin
        req5 = 5'b00100;
        exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
      end
      step();
      e = exp_q.pop_front();
      eg = 5'(1) << e;
      tests++;
      if (v5 !== 1'b1 || idx5 !== 3'(e) || g5 !== eg) begin
        fails++;
        $display("FAIL n5_seq[%0d]: valid=%b idx=%0d grant=%b required 1/%0d/%b", c, v5, idx5, g5, e, eg);
      end
    end
  endtask

  task automatic test_mode_switch();
    int unsigned e;
    logic [7:0] eg;
    logic m [4];
    int unsigned x [4];
    m[0] = 1'b1; x[0] = 3;
    m[1] = 1'b0; x[1] = 3;
    m[2] = 1'b1; x[2] = 1;
    m[3] = 1'b1; x[3] = 3;
    do_reset();
    req8 = 8'h0A; rdy8 = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      mode8 = m[c];
      exp_q.push_back(x[c]);
      step();
      e = exp_q.pop_front();
      eg = 8'(1) << e;
      tests++;
      if (v8 !== 1'b1 || idx8 !== 3'(e) || g8 !== eg) begin
        fails++;
        $display("FAIL mode_switch[%0d]: valid=%b idx=%0d grant=%h required 1/%0d/%h", c, v8, idx8, g8, e, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_backpressure();
    test_round_robin();
    test_n5();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
